// File: rtl/clm_mixcol_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : clm_mixcol_seq_if
// Purpose  : Handshake bundle for the sequential encoded MixColumns block:
//            column input, refresh-word input and result output channels.
// Revision : 1.0 - initial release
// ============================================================================
interface clm_mixcol_seq_if #(
    parameter int d = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][d+7:0]     in_col;     // index 0 is row 0 (a0)
    logic                  rnd_valid;
    logic                  rnd_ready;
    logic [d-1:0]          rnd;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0][d+7:0]     out_col;    // index 0 is row 0 (b0)

    // Producer/consumer side (drives columns and refresh words)
    modport master (
        output in_valid, in_col, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, out_col
    );

    // Block side
    modport slave (
        input  in_valid, in_col, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, out_col
    );
endinterface
`default_nettype wire

// File: rtl/clm_mixcol_seq.sv
`default_nettype none
// ============================================================================
// Module   : clm_mixcol_seq
// Purpose  : Sequential MixColumns on redundancy-encoded bytes. One shared
//            encoded multiply-by-2 (linear map L[1] plus refresh B_ext_MC*rnd)
//            is reused over four steps, one fresh refresh word per step; the
//            result column is then formed by plain XOR of encoded bytes.
// Config   : CLM_MC_STALL_CNT_EN adds a saturating 16-bit stall_cnt output
//            counting MUL cycles spent waiting for a refresh word.
// Revision : 1.0 - initial release
// ============================================================================
module clm_mixcol_seq #(
    parameter int d = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    clm_mixcol_seq_if.slave              bus,
    // Multiplication matrices: L[c][j] is output-bit row j of the map for
    // constant c+1; only the multiply-by-2 row (c=1) is used here.
    input  logic [2:0][d+7:0][d+7:0]     L,
    // Reduction encoder: B_ext_MC[i] is the encoded image of refresh bit i.
    input  logic [d-1:0][d+7:0]          B_ext_MC
`ifdef CLM_MC_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int c_w = 8 + d;

    typedef logic [c_w-1:0] state_t;
    typedef logic [d-1:0]   red_poly_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e           state_q, state_d;
    logic [1:0]     k_q, k_d;
    state_t [3:0]   a_q, a_d;
    state_t [3:0]   m_q, m_d;
    state_t [3:0]   out_q, out_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    state_t         w_sel_a;
    state_t         w_m;
    red_poly_t      w_rnd;

    // Rows for constants 1 and 3 belong to the shared matrix port but are
    // not needed by this multiply-by-2-only datapath.
    logic           w_unused_l;
    assign w_unused_l = ^{L[0], L[2]};

    assign w_rnd = bus.rnd;

    // Single encoded multiply-by-2 shared across the four steps
    always_comb begin
        w_sel_a = a_q[k_q];
        w_m     = '0;
        for (int j = 0; j < c_w; j++) begin
            w_m[j] = ^(L[1][j] & w_sel_a);
        end
        for (int i = 0; i < d; i++) begin
            if (w_rnd[i]) begin
                w_m = w_m ^ B_ext_MC[i];
            end
        end
    end

    // Next-state and datapath update for the IDLE -> MUL -> DONE sequence
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        m_d         = m_q;
        out_d       = out_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.in_col;
                    k_d        = 2'd0;
                    state_d    = MUL;
                    in_ready_d = 1'b0;
                end
            end
            MUL: begin
                // Without a fresh word nothing moves: no multiply, k held.
                if (bus.rnd_valid) begin
                    m_d[k_q] = w_m;
                    k_d      = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        // Last product is taken from m_d so it is usable now.
                        for (int i = 0; i < 4; i++) begin
                            out_d[i] = m_d[i] ^ m_d[(i + 1) % 4]
                                     ^ a_q[(i + 1) % 4] ^ a_q[(i + 2) % 4]
                                     ^ a_q[(i + 3) % 4];
                        end
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any column in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            a_q         <= '0;
            m_q         <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            m_q         <= m_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_col   = out_q;
    // Refresh words are consumed same-cycle, so this handshake is combinational.
    assign bus.rnd_ready = (state_q == MUL) && bus.rnd_valid;

`ifdef CLM_MC_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of MUL cycles spent waiting for a refresh word
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == MUL) && !bus.rnd_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clm_mixcol_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_clm_mixcol_seq
// Purpose  : Self-checking bench for clm_mixcol_seq. Encoded bytes are
//            modelled as polynomials: encode(x,r) = x + r*P, decode = c mod P,
//            encoded doubling = X*c mod (P*Q) + r*P, with P the AES polynomial
//            and Q = X^2+X+1. Decoded results are checked against byte-level
//            AES MixColumns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clm_mixcol_seq;

    localparam int D = 2;
    localparam int W = 8 + D;
    localparam logic [31:0] P_AES = 32'h11B;
    localparam logic [31:0] Q_RED = 32'h007;

    logic clk;
    logic rst;
    logic [2:0][W-1:0][W-1:0] L;
    logic [D-1:0][W-1:0]      B;
    logic [31:0]              pq;
`ifdef CLM_MC_STALL_CNT_EN
    logic [15:0]              stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int rnd_hs_total = 0;

    clm_mixcol_seq_if #(.d(D)) bus ();

    clm_mixcol_seq #(.d(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .L        (L),
        .B_ext_MC (B)
`ifdef CLM_MC_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of refresh-word handshakes seen at clock edges
    always @(posedge clk) begin
        if (bus.rnd_valid && bus.rnd_ready) rnd_hs_total <= rnd_hs_total + 1;
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] clmul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (b[i]) r = r ^ (a << i);
        return r;
    endfunction

    function automatic logic [31:0] pmod(input logic [31:0] a, input logic [31:0] m, input int mdeg);
        logic [31:0] r;
        r = a;
        for (int i = 31; i >= mdeg; i--) if (r[i]) r = r ^ (m << (i - mdeg));
        return r;
    endfunction

    function automatic logic [W-1:0] encode(input logic [7:0] x, input logic [D-1:0] red);
        logic [31:0] r;
        r = 32'(x) ^ clmul(32'(red), P_AES);
        return r[W-1:0];
    endfunction

    function automatic logic [7:0] decode(input logic [W-1:0] c);
        logic [31:0] r;
        r = pmod(32'(c), P_AES, 8);
        return r[7:0];
    endfunction

    function automatic logic [W-1:0] enc_mul2(input logic [W-1:0] c, input logic [D-1:0] w);
        logic [31:0] r;
        r = pmod(32'(c) << 1, pq, W) ^ clmul(32'(w), P_AES);
        return r[W-1:0];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [3:0][7:0] mixcol_plain(input logic [3:0][7:0] a);
        logic [3:0][7:0] b;
        for (int i = 0; i < 4; i++)
            b[i] = gmul(a[i], 8'h02) ^ gmul(a[(i + 1) % 4], 8'h03)
                 ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
        return b;
    endfunction

    // ---------------- checking ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One column end to end: optional stall before step stall_k, optional
    // out_ready hold-off in DONE.
    task automatic run_col(input logic [3:0][7:0] col, input logic [3:0][7:0] exp_dec,
                           input bit zero_mode, input int stall_k, input int stall_len,
                           input int hold);
        logic [3:0][W-1:0] a, m, b;
        logic [3:0][D-1:0] w;
        logic [4*W-1:0]    held;
        logic              bad_hold;
        int cyc, exp_cyc, waited, hs0;
        for (int i = 0; i < 4; i++) begin
            a[i] = encode(col[i], zero_mode ? '0 : D'($urandom));
            w[i] = zero_mode ? '0 : D'($urandom);
        end
        for (int i = 0; i < 4; i++) m[i] = enc_mul2(a[i], w[i]);
        for (int i = 0; i < 4; i++)
            b[i] = m[i] ^ m[(i + 1) % 4] ^ a[(i + 1) % 4] ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
        exp_cyc = 5 + ((stall_k >= 0 && stall_k <= 3) ? stall_len : 0);

        @(negedge clk);
        hs0 = rnd_hs_total;
        chk1("idle_in_ready", bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_col    = a;
        bus.rnd_valid = 1'b1;
        bus.rnd       = D'($urandom);
        #1;
        chk1("idle_rnd_ready", bus.rnd_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        bus.in_col = ~a;              // must be ignored outside IDLE
        for (int k = 0; k < 4; k++) begin
            if (k == stall_k) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.rnd_valid = 1'b0;
                    bus.rnd       = D'($urandom);
                    #1;
                    chk1("stall_rnd_ready", bus.rnd_ready, 1'b0);
                    @(posedge clk);
                    @(negedge clk);
                    cyc++;
                end
            end
            bus.rnd_valid = 1'b1;
            bus.rnd       = w[k];
            #1;
            chk1("mul_rnd_ready", bus.rnd_ready, 1'b1);
            chk1("mul_out_valid", bus.out_valid, 1'b0);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.rnd = D'($urandom);
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            waited++;
        end
        chkv("latency", 64'(cyc), 64'(exp_cyc));
        chk1("out_valid", bus.out_valid, 1'b1);
        chkv("enc_out_col", 64'(bus.out_col), 64'(b));
        for (int i = 0; i < 4; i++) chkv("dec_out_col", 64'(decode(bus.out_col[i])), 64'(exp_dec[i]));
        held = bus.out_col;
        bad_hold = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (bus.out_col !== held || bus.in_ready !== 1'b0 || bus.rnd_ready !== 1'b0
                || bus.out_valid !== 1'b1) bad_hold = 1'b1;
        end
        if (hold > 0) chk1("done_hold_stable", bad_hold, 1'b0);
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk1("released_out_valid", bus.out_valid, 1'b0);
        chk1("back_idle_in_ready", bus.in_ready, 1'b1);
        chkv("rnd_handshakes", 64'(rnd_hs_total - hs0), 64'd4);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0][7:0] rc;
        logic            seen_valid;

        pq = clmul(P_AES, Q_RED);
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < W; i++) begin
                logic [31:0] img;
                img = pmod(clmul(32'(1) << i, 32'(c + 1)), pq, W);
                for (int j = 0; j < W; j++) L[c][j][i] = img[j];
            end
        for (int i = 0; i < D; i++) begin
            logic [31:0] bi;
            bi = P_AES << i;
            B[i] = bi[W-1:0];
        end

        bus.in_valid  = 1'b0;
        bus.in_col    = '0;
        bus.rnd_valid = 1'b0;
        bus.rnd       = '0;
        bus.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        #1;
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst_rnd_ready", bus.rnd_ready, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chkv("rst_out_col", 64'(bus.out_col), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // All-zero column, zero redundancy and zero refresh
        run_col('0, '0, 1'b1, -1, 0, 0);
        // Known AES vector with random refresh
        run_col({8'h45, 8'h53, 8'h13, 8'hDB}, {8'hBC, 8'hA1, 8'h4D, 8'h8E}, 1'b0, -1, 0, 0);
        // Three stall cycles before step 2
        run_col({8'h5C, 8'h22, 8'h0A, 8'hF2}, {8'h9D, 8'h58, 8'hDC, 8'h9F}, 1'b0, 2, 3, 0);
        // Downstream back-pressure for ten cycles
        rc = $urandom;
        run_col(rc, mixcol_plain(rc), 1'b0, -1, 0, 10);

        // Reset while at step 2 drops the column
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_col   = {encode(8'h11, 2'd1), encode(8'h22, 2'd2), encode(8'h33, 2'd3), encode(8'h44, 2'd0)};
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b1;
        bus.rnd       = D'($urandom);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("midrst_in_ready", bus.in_ready, 1'b1);
        chk1("midrst_rnd_ready", bus.rnd_ready, 1'b0);
        chk1("midrst_out_valid", bus.out_valid, 1'b0);
        chkv("midrst_out_col", 64'(bus.out_col), 64'd0);
        #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        chk1("post_rst_no_output", seen_valid, 1'b0);
        bus.rnd_valid = 1'b0;
        run_col({4{8'hC6}}, {4{8'hC6}}, 1'b0, -1, 0, 0);

        // Random columns, stalls and back-pressure
        for (int n = 0; n < 6; n++) begin
            rc = $urandom;
            run_col(rc, mixcol_plain(rc), 1'b0, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

`ifdef CLM_MC_STALL_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        chkv("stall_cnt_rst", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        rc = $urandom;
        run_col(rc, mixcol_plain(rc), 1'b0, 1, 2, 0);
        rc = $urandom;
        run_col(rc, mixcol_plain(rc), 1'b0, 3, 3, 0);
        chkv("stall_cnt_five", 64'(stall_cnt), 64'd5);
        force dut.stall_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        rc = $urandom;
        run_col(rc, mixcol_plain(rc), 1'b0, 0, 2, 0);
        chkv("stall_cnt_sat", 64'(stall_cnt), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
